// File: rtl/ula_serial_ctrl.sv
// Bit-serial sequencer for an external 1-bit ALU slice: walks a WIDTH-bit
// operand pair LSB first, chains the carry through a register, assembles the result.
module ula_serial_ctrl #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic [2:0]       op_in,
   input  logic             ainv_in,
   input  logic             binv_in,
   input  logic             cin_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             zero,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_ainv,
   output logic             slice_binv,
   output logic             slice_cinv,
   output logic [2:0]       slice_op,
   input  logic             slice_s,
   input  logic             slice_cout
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res_sh;
   logic [2:0]       r_op;
   logic             r_ainv;
   logic             r_binv;
   logic             r_carry;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_result;
   logic             r_cout;
   logic             r_zero;
   logic             r_done;
   logic             w_last_bit;

   assign w_last_bit = (r_count == CNT_W'(WIDTH - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic; start outside IDLE is simply not looked at
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_RUN;
            end else begin
               w_next = S_IDLE;
            end
         end
         S_RUN: begin
            if (w_last_bit) begin
               w_next = S_DONE;
            end else begin
               w_next = S_RUN;
            end
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Operand/result shift registers, carry chain, bit counter and result latch
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a_sh   <= {WIDTH{1'b0}};
         r_b_sh   <= {WIDTH{1'b0}};
         r_res_sh <= {WIDTH{1'b0}};
         r_op     <= 3'd0;
         r_ainv   <= 1'b0;
         r_binv   <= 1'b0;
         r_carry  <= 1'b0;
         r_count  <= {CNT_W{1'b0}};
         r_result <= {WIDTH{1'b0}};
         r_cout   <= 1'b0;
         r_zero   <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a_sh   <= a_in;
                  r_b_sh   <= b_in;
                  r_res_sh <= {WIDTH{1'b0}};
                  r_op     <= op_in;
                  r_ainv   <= ainv_in;
                  r_binv   <= binv_in;
                  r_carry  <= cin_in;
                  r_count  <= {CNT_W{1'b0}};
               end else begin
                  r_count  <= r_count;
               end
            end
            S_RUN: begin
               r_res_sh <= {slice_s, r_res_sh[WIDTH-1:1]};
               r_carry  <= slice_cout;
               r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
               r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
               r_count  <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            S_DONE: begin
               r_result <= r_res_sh;
               r_cout   <= r_carry;
               r_zero   <= (r_res_sh == {WIDTH{1'b0}});
               r_done   <= 1'b1;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   // Status and slice drive decoded from state; slice is held quiet outside RUN
   always_comb begin
      ready      = 1'b0;
      busy       = 1'b0;
      slice_a    = 1'b0;
      slice_b    = 1'b0;
      slice_ainv = 1'b0;
      slice_binv = 1'b0;
      slice_cinv = 1'b0;
      slice_op   = 3'd0;
      case (r_state)
         S_IDLE: ready = 1'b1;
         S_RUN: begin
            busy       = 1'b1;
            slice_a    = r_a_sh[0];
            slice_b    = r_b_sh[0];
            slice_ainv = r_ainv;
            slice_binv = r_binv;
            slice_cinv = r_carry;
            slice_op   = r_op;
         end
         S_DONE:  ready = 1'b0;
         default: ready = 1'b0;
      endcase
   end

   assign done   = r_done;
   assign result = r_result;
   assign cout   = r_cout;
   assign zero   = r_zero;

endmodule

// File: doc/ula_serial_ctrl.md
Name: ula_serial_ctrl

Overview:
Bit-serial sequencer that drives the 1-bit ALU slice (A, B, Ainv, Binv, Cinv, op -> S, Cout) across a WIDTH-bit operand pair, one bit per clock, LSB first. It latches operands on a start/ready handshake, chains the slice carry through a register, assembles the result, and reports done, cout and zero. The 1-bit slice is instantiated outside this block; the controller owns only sequencing.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  request; accepted only when ready=1
a_in  in  WIDTH  operand A
b_in  in  WIDTH  operand B
op_in  in  3  slice op code, passed through unchanged
ainv_in  in  1  invert A for the whole operation
binv_in  in  1  invert B for the whole operation
cin_in  in  1  carry into bit 0
ready  out  1  idle, start will be accepted
busy  out  1  operation in progress
done  out  1  one-cycle pulse, result valid
result  out  WIDTH  assembled result, held until next accepted start
cout  out  1  carry out of bit WIDTH-1
zero  out  1  result == 0, registered with result
slice_a  out  1  to slice A
slice_b  out  1  to slice B
slice_ainv  out  1  to slice Ainv
slice_binv  out  1  to slice Binv
slice_cinv  out  1  to slice Cinv (carry in)
slice_op  out  3  to slice op
slice_s  in  1  from slice S (combinational)
slice_cout  in  1  from slice Cout (combinational)

Behaviour:
- Clock: one clock, clk; reset is synchronous and active-high (rst).
- Reset values: state=IDLE, ready=1, busy=0, done=0, result=0, cout=0, zero=1, count=0, all slice_* outputs 0.
- States: IDLE, RUN, DONE.
- IDLE: ready=1. Start=1 latches a_in/b_in into shift registers, op/ainv/binv into config registers, carry register <= cin_in, count <= 0; next state RUN. result/cout/zero keep their previous values until DONE.
- RUN: busy=1, ready=0. slice_a=a_sh[0], slice_b=b_sh[0], slice_cinv=carry reg, slice_op/ainv/binv from config registers. Each clock: result shift reg <= {slice_s, res_sh[WIDTH-1:1]}; carry <= slice_cout; a_sh, b_sh shift right; count++. When count==WIDTH-1, transfer to DONE.
- DONE (one cycle): result <= res_sh, cout <= carry, zero <= (res_sh==0), done=1, busy=0; next state IDLE.
- Latency: start accepted at edge N -> done high during cycle N+WIDTH+1. Throughput: one op per WIDTH+2 cycles.
- Start while busy or in DONE: ignored, no queuing, no effect on the current operation.
- Slice outputs are 0 in IDLE and DONE, so the slice is quiescent.
- op_in is not decoded. The carry chain is always active. Slice encoding used by the bench: 0=AND, 1=OR, 2=ADD. Subtract is ADD with binv=1, cin=1.
- rst mid-RUN: the next cycle is IDLE with all reset values. The partial result is discarded and done does not pulse.
- rst and start in the same cycle: rst wins; start is not accepted.

Test Plan:
- Reset: rst=1 for 2 cycles -> ready=1, busy=0, done=0, result=0x00, cout=0, zero=1.
- ADD, WIDTH=8: a=0x3C, b=0x05, op=2, cin=0 -> done pulses 9 cycles after start is accepted; result=0x41, cout=0, zero=0; busy high for exactly 8 cycles.
- ADD overflow: a=0xFF, b=0x01, cin=0 -> result=0x00, cout=1, zero=1.
- SUB: a=0x10, b=0x01, op=2, binv=1, cin=1 -> result=0x0F, cout=1. Then AND a=0xF0, b=0x3C, op=0 -> result=0x30. A start pulse with different operands at RUN cycle 3 is ignored: result stays 0x30 and exactly one done pulse occurs.
- Reset mid-op: start ADD 0x7F+0x01, assert rst at RUN bit 3 -> next cycle ready=1, result=0x00, no done pulse. A following ADD 0x02+0x03 -> result=0x05.
- Back-to-back: start held high continuously with ADD 0x01+0x01 -> operations are accepted only in IDLE, and done pulses every 10 cycles with result=0x02.
